pipe_sequencer: RTL and testbench

//   Parametrised multi-cycle pipeline sequencer for the core. Owns the run-mode FSM
//   (IDLE/LOAD/RUN/HALT), the stage counter, PC register, pipeline-register update

---
 rtl/pipe_sequencer.sv | 172 +++++++++++++++++
 tb/tb_pipe_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_sequencer.sv
// pipe_sequencer: run-mode FSM (IDLE/LOAD/RUN/HALT) for a multi-cycle pipeline.
// It steps the stage counter, holds the PC, and issues one-hot pipeline-register
// update strobes. The execute stage waits out a variable latency plus an external
// busy signal, with an optional timeout fault. It also counts retired instructions.
//
// Handshakes:
//   - boot_req_i  : level request. It is taken in IDLE or HALT and ignored in LOAD and RUN.
//   - load_done_i : must be high in the same cycle as boot_ack_i to enter RUN.
//   - boot_ack_i  : see load_done_i.
//   - exec_busy_i : stalls the execute stage while high. The stage completes only
//                   when the latency count has reached wait_q and exec_busy_i is low.
module pipe_sequencer #(
    parameter int              NSTAGE     = 4,
    parameter int              EXEC_STAGE = 2,
    parameter int              LAT_W      = 5,
    parameter int              PC_W       = 32,
    parameter logic [PC_W-1:0] RESET_PC   = '0,
    parameter int              TIMEOUT    = 0,
    parameter int              CNT_W      = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      boot_req_i,
    input  logic                      load_done_i,
    input  logic                      boot_ack_i,
    input  logic [LAT_W-1:0]          wait_time_i,
    input  logic                      exec_busy_i,
    input  logic [PC_W-1:0]           npc_i,
    input  logic                      stop_req_i,
    output logic [1:0]                mode_o,
    output logic [$clog2(NSTAGE)-1:0] cur_stage_o,
    output logic [NSTAGE-1:0]         stage_upd_o,
    output logic                      exec_start_o,
    output logic [PC_W-1:0]           pc_o,
    output logic                      timeout_err_o,
    output logic [CNT_W-1:0]          retire_cnt_o
);

    localparam int SW = $clog2(NSTAGE);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [SW-1:0] EXEC_IDX = SW'(EXEC_STAGE);
    localparam logic [SW-1:0] PRE_IDX  = SW'(EXEC_STAGE - 1);
    localparam logic [SW-1:0] LAST_IDX = SW'(NSTAGE - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic          TO_EN    = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        MODE_IDLE = 2'd0,
        MODE_LOAD = 2'd1,
        MODE_RUN  = 2'd2,
        MODE_HALT = 2'd3
    } mode_t;

    mode_t             mode_q, mode_d;
    logic [SW-1:0]     stage_q, stage_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [LAT_W-1:0]  wait_q, wait_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [TW-1:0]     exec_cyc_q, exec_cyc_d;
    logic              exec_start_q, exec_start_d;
    logic              timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0]  retire_q, retire_d;

    logic in_exec;
    logic exec_done;
    logic exec_timeout;

    // Execute-stage status: completion has priority over the timeout fault.
    assign in_exec      = (mode_q == MODE_RUN) && (stage_q == EXEC_IDX);
    assign exec_done    = in_exec && (lat_q == wait_q) && !exec_busy_i;
    assign exec_timeout = in_exec && !exec_done && TO_EN && (exec_cyc_q == TO_LAST);

    // State register: all sequencer state, with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q        <= MODE_IDLE;
            stage_q       <= '0;
            pc_q          <= RESET_PC;
            wait_q        <= '0;
            lat_q         <= '0;
            exec_cyc_q    <= '0;
            exec_start_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            retire_q      <= '0;
        end else begin
            mode_q        <= mode_d;
            stage_q       <= stage_d;
            pc_q          <= pc_d;
            wait_q        <= wait_d;
            lat_q         <= lat_d;
            exec_cyc_q    <= exec_cyc_d;
            exec_start_q  <= exec_start_d;
            timeout_err_q <= timeout_err_d;
            retire_q      <= retire_d;
        end
    end

    // Next-state logic: mode transitions, stage stepping, and per-stage side effects.
    always_comb begin
        mode_d        = mode_q;
        stage_d       = stage_q;
        pc_d          = pc_q;
        wait_d        = wait_q;
        lat_d         = lat_q;
        exec_cyc_d    = exec_cyc_q;
        exec_start_d  = 1'b0;
        timeout_err_d = timeout_err_q;
        retire_d      = retire_q;
        unique case (mode_q)
            MODE_IDLE: begin
                if (boot_req_i) mode_d = MODE_LOAD;
            end
            MODE_LOAD: begin
                if (load_done_i && boot_ack_i) mode_d = MODE_RUN;
            end
            MODE_RUN: begin
                if (stage_q == EXEC_IDX) begin
                    if (exec_done) begin
                        stage_d = stage_q + SW'(1);
                    end else if (exec_timeout) begin
                        timeout_err_d = 1'b1;
                        mode_d        = MODE_HALT;
                    end else begin
                        if (lat_q < wait_q) lat_d = lat_q + LAT_W'(1);
                        exec_cyc_d = exec_cyc_q + TW'(1);
                    end
                end else if (stage_q == LAST_IDX) begin
                    retire_d = retire_q + CNT_W'(1);
                    if (stop_req_i) mode_d = MODE_HALT;
                    else            stage_d = '0;
                end else begin
                    stage_d = stage_q + SW'(1);
                    // Entering the execute stage: capture the instruction's PC and latency.
                    if (stage_q == PRE_IDX) begin
                        pc_d         = npc_i;
                        wait_d       = wait_time_i;
                        lat_d        = '0;
                        exec_cyc_d   = '0;
                        exec_start_d = 1'b1;
                    end
                end
            end
            MODE_HALT: begin
                // Re-boot goes straight to LOAD; the retired count survives.
                if (boot_req_i) begin
                    mode_d        = MODE_LOAD;
                    pc_d          = RESET_PC;
                    stage_d       = '0;
                    timeout_err_d = 1'b0;
                end
            end
            default: mode_d = MODE_IDLE;
        endcase
    end

    // Output logic: one-hot update strobe for the current stage, suppressed during reset.
    always_comb begin
        stage_upd_o = '0;
        if (!rst_i && (mode_q == MODE_RUN) && ((stage_q != EXEC_IDX) || exec_done)) begin
            stage_upd_o = NSTAGE'(1) << stage_q;
        end
    end

    assign mode_o        = mode_q;
    assign cur_stage_o   = stage_q;
    assign exec_start_o  = exec_start_q;
    assign pc_o          = pc_q;
    assign timeout_err_o = timeout_err_q;
    assign retire_cnt_o  = retire_q;

endmodule

// File: tb/tb_pipe_sequencer.sv
// Testbench for pipe_sequencer (NSTAGE=4, EXEC_STAGE=2, TIMEOUT=8).
// Each cycle the bench drives inputs at the falling edge and checks outputs 1 ns later.
module tb_pipe_sequencer;

  logic        clk;
  logic        rst;
  logic        boot_req, load_done, boot_ack, exec_busy, stop_req;
  logic [4:0]  wait_time;
  logic [31:0] npc;
  logic [1:0]  mode;
  logic [1:0]  cur_stage;
  logic [3:0]  stage_upd;
  logic        exec_start;
  logic [31:0] pc;
  logic        timeout_err;
  logic [31:0] retire_cnt;

  int errors = 0;
  int checks = 0;

  pipe_sequencer #(
    .NSTAGE(4), .EXEC_STAGE(2), .LAT_W(5), .PC_W(32),
    .RESET_PC(32'd0), .TIMEOUT(8), .CNT_W(32)
  ) dut (
    .clk_i(clk), .rst_i(rst), .boot_req_i(boot_req), .load_done_i(load_done),
    .boot_ack_i(boot_ack), .wait_time_i(wait_time), .exec_busy_i(exec_busy),
    .npc_i(npc), .stop_req_i(stop_req), .mode_o(mode), .cur_stage_o(cur_stage),
    .stage_upd_o(stage_upd), .exec_start_o(exec_start), .pc_o(pc),
    .timeout_err_o(timeout_err), .retire_cnt_o(retire_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        boot, ld, ack;
    logic [4:0]  wt;
    logic        busy;
    logic [31:0] npc;
    logic        stop;
    logic [1:0]  m, s;
    logic [3:0]  u;
    logic        es;
    logic [31:0] pc;
    logic        te;
    logic [31:0] rc;
  } vec_t;

  vec_t vecs[25];

  function automatic vec_t mk(input logic b, input logic l, input logic a,
                              input logic [4:0] w, input logic bz, input logic [31:0] n,
                              input logic st, input logic [1:0] m, input logic [1:0] s,
                              input logic [3:0] u, input logic es, input logic [31:0] p,
                              input logic te, input logic [31:0] rc);
    vec_t v;
    v.boot = b; v.ld = l; v.ack = a; v.wt = w; v.busy = bz; v.npc = n; v.stop = st;
    v.m = m; v.s = s; v.u = u; v.es = es; v.pc = p; v.te = te; v.rc = rc;
    return v;
  endfunction

  // driver: apply one cycle of inputs at the falling edge, settle 1 ns
  task automatic step(input logic r, input logic b, input logic l, input logic a,
                      input logic [4:0] w, input logic bz, input logic [31:0] n,
                      input logic st);
    @(negedge clk);
    rst = r; boot_req = b; load_done = l; boot_ack = a;
    wait_time = w; exec_busy = bz; npc = n; stop_req = st;
    #1;
  endtask

  // scoreboard compare of the full output bundle
  task automatic check(input string name, input logic [1:0] m, input logic [1:0] s,
                       input logic [3:0] u, input logic es, input logic [31:0] p,
                       input logic te, input logic [31:0] rc);
    checks++;
    if ({mode, cur_stage, stage_upd, exec_start, pc, timeout_err, retire_cnt} !==
        {m, s, u, es, p, te, rc}) begin
      errors++;
      $display("FAIL %s: got mode=%0d stg=%0d upd=%b es=%b pc=%0d terr=%b ret=%0d, want mode=%0d stg=%0d upd=%b es=%b pc=%0d terr=%b ret=%0d",
               name, mode, cur_stage, stage_upd, exec_start, pc, timeout_err, retire_cnt,
               m, s, u, es, p, te, rc);
    end
  endtask

  initial begin
    rst = 1'b1; boot_req = 1'b0; load_done = 1'b0; boot_ack = 1'b0;
    wait_time = 5'd0; exec_busy = 1'b0; npc = 32'd0; stop_req = 1'b0;

    // boot, one single-cycle-execute instruction, then a busy-extended and a latency-only one
    //            boot  ld    ack   wt     busy  npc     stop   mode  stg   upd      es    pc      te    ret
    vecs[0]  = mk(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0,  1'b0, 2'd0, 2'd0, 4'b0000, 1'b0, 32'd0,  1'b0, 32'd0);
    vecs[1]  = mk(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0,  1'b0, 2'd0, 2'd0, 4'b0000, 1'b0, 32'd0,  1'b0, 32'd0);
    vecs[2]  = mk(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0,  1'b0, 2'd1, 2'd0, 4'b0000, 1'b0, 32'd0,  1'b0, 32'd0);
    vecs[3]  = mk(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 32'd0,  1'b0, 2'd1, 2'd0, 4'b0000, 1'b0, 32'd0,  1'b0, 32'd0);
    vecs[4]  = mk(1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 32'd0,  1'b0, 2'd1, 2'd0, 4'b0000, 1'b0, 32'd0,  1'b0, 32'd0);
    vecs[5]  = mk(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 32'd4,  1'b0, 2'd2, 2'd0, 4'b0001, 1'b0, 32'd0,  1'b0, 32'd0);
    vecs[6]  = mk(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd4,  1'b0, 2'd2, 2'd1, 4'b0010, 1'b0, 32'd0,  1'b0, 32'd0);
    vecs[7]  = mk(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0,  1'b0, 2'd2, 2'd2, 4'b0100, 1'b1, 32'd4,  1'b0, 32'd0);
    vecs[8]  = mk(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0,  1'b0, 2'd2, 2'd3, 4'b1000, 1'b0, 32'd4,  1'b0, 32'd0);
    vecs[9]  = mk(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0,  1'b0, 2'd2, 2'd0, 4'b0001, 1'b0, 32'd4,  1'b0, 32'd1);
    vecs[10] = mk(1'b0, 1'b0, 1'b0, 5'd3, 1'b0, 32'd8,  1'b0, 2'd2, 2'd1, 4'b0010, 1'b0, 32'd4,  1'b0, 32'd1);
    vecs[11] = mk(1'b0, 1'b0, 1'b0, 5'd7, 1'b1, 32'd0,  1'b0, 2'd2, 2'd2, 4'b0000, 1'b1, 32'd8,  1'b0, 32'd1);
    vecs[12] = mk(1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 32'd0,  1'b0, 2'd2, 2'd2, 4'b0000, 1'b0, 32'd8,  1'b0, 32'd1);
    vecs[13] = mk(1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 32'd0,  1'b0, 2'd2, 2'd2, 4'b0000, 1'b0, 32'd8,  1'b0, 32'd1);
    vecs[14] = mk(1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 32'd0,  1'b0, 2'd2, 2'd2, 4'b0000, 1'b0, 32'd8,  1'b0, 32'd1);
    vecs[15] = mk(1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 32'd0,  1'b0, 2'd2, 2'd2, 4'b0000, 1'b0, 32'd8,  1'b0, 32'd1);
    vecs[16] = mk(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0,  1'b0, 2'd2, 2'd2, 4'b0100, 1'b0, 32'd8,  1'b0, 32'd1);
    vecs[17] = mk(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0,  1'b0, 2'd2, 2'd3, 4'b1000, 1'b0, 32'd8,  1'b0, 32'd1);
    vecs[18] = mk(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0,  1'b0, 2'd2, 2'd0, 4'b0001, 1'b0, 32'd8,  1'b0, 32'd2);
    vecs[19] = mk(1'b0, 1'b0, 1'b0, 5'd2, 1'b0, 32'd12, 1'b0, 2'd2, 2'd1, 4'b0010, 1'b0, 32'd8,  1'b0, 32'd2);
    vecs[20] = mk(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0,  1'b0, 2'd2, 2'd2, 4'b0000, 1'b1, 32'd12, 1'b0, 32'd2);
    vecs[21] = mk(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0,  1'b0, 2'd2, 2'd2, 4'b0000, 1'b0, 32'd12, 1'b0, 32'd2);
    vecs[22] = mk(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0,  1'b0, 2'd2, 2'd2, 4'b0100, 1'b0, 32'd12, 1'b0, 32'd2);
    vecs[23] = mk(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0,  1'b0, 2'd2, 2'd3, 4'b1000, 1'b0, 32'd12, 1'b0, 32'd2);
    vecs[24] = mk(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0,  1'b0, 2'd2, 2'd0, 4'b0001, 1'b0, 32'd12, 1'b0, 32'd3);

    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0);

    for (int i = 0; i < 25; i++) begin
      step(1'b0, vecs[i].boot, vecs[i].ld, vecs[i].ack, vecs[i].wt, vecs[i].busy,
           vecs[i].npc, vecs[i].stop);
      check($sformatf("vec%0d", i), vecs[i].m, vecs[i].s, vecs[i].u, vecs[i].es,
            vecs[i].pc, vecs[i].te, vecs[i].rc);
    end

    // halt on stop_req at the last stage, then re-boot
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd16, 1'b0);
    check("stop_s1", 2'd2, 2'd1, 4'b0010, 1'b0, 32'd12, 1'b0, 32'd3);
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0);
    check("stop_s2", 2'd2, 2'd2, 4'b0100, 1'b1, 32'd16, 1'b0, 32'd3);
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b1);
    check("stop_s3", 2'd2, 2'd3, 4'b1000, 1'b0, 32'd16, 1'b0, 32'd3);
    step(1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 32'd0, 1'b0);
    check("halted", 2'd3, 2'd3, 4'b0000, 1'b0, 32'd16, 1'b0, 32'd4);
    step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0);
    check("halt_hold", 2'd3, 2'd3, 4'b0000, 1'b0, 32'd16, 1'b0, 32'd4);
    step(1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 32'd0, 1'b0);
    check("reboot_load", 2'd1, 2'd0, 4'b0000, 1'b0, 32'd0, 1'b0, 32'd4);

    // execute timeout with exec_busy stuck high
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0);
    check("to_s0", 2'd2, 2'd0, 4'b0001, 1'b0, 32'd0, 1'b0, 32'd4);
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd20, 1'b0);
    check("to_s1", 2'd2, 2'd1, 4'b0010, 1'b0, 32'd0, 1'b0, 32'd4);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 32'd0, 1'b0);
      check($sformatf("to_busy%0d", i), 2'd2, 2'd2, 4'b0000, (i == 0), 32'd20, 1'b0, 32'd4);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 32'd0, 1'b0);
    check("to_fault", 2'd3, 2'd2, 4'b0000, 1'b0, 32'd20, 1'b1, 32'd4);
    step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 32'd0, 1'b0);
    check("to_fault_hold", 2'd3, 2'd2, 4'b0000, 1'b0, 32'd20, 1'b1, 32'd4);
    step(1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 32'd0, 1'b0);
    check("to_reboot", 2'd1, 2'd0, 4'b0000, 1'b0, 32'd0, 1'b0, 32'd4);

    // busy released on the last allowed cycle: completion wins over timeout
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0);
    check("late_s0", 2'd2, 2'd0, 4'b0001, 1'b0, 32'd0, 1'b0, 32'd4);
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd24, 1'b0);
    check("late_s1", 2'd2, 2'd1, 4'b0010, 1'b0, 32'd0, 1'b0, 32'd4);
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 32'd0, 1'b0);
      check($sformatf("late_busy%0d", i), 2'd2, 2'd2, 4'b0000, (i == 0), 32'd24, 1'b0, 32'd4);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0);
    check("late_done", 2'd2, 2'd2, 4'b0100, 1'b0, 32'd24, 1'b0, 32'd4);
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0);
    check("late_s3", 2'd2, 2'd3, 4'b1000, 1'b0, 32'd24, 1'b0, 32'd4);

    // reset in the middle of the execute stage
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0);
    check("rst_s0", 2'd2, 2'd0, 4'b0001, 1'b0, 32'd24, 1'b0, 32'd5);
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd28, 1'b0);
    check("rst_s1", 2'd2, 2'd1, 4'b0010, 1'b0, 32'd24, 1'b0, 32'd5);
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0);
    check("rst_cycle", 2'd2, 2'd2, 4'b0000, 1'b1, 32'd28, 1'b0, 32'd5);
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0);
    check("rst_after", 2'd0, 2'd0, 4'b0000, 1'b0, 32'd0, 1'b0, 32'd0);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
